vsync_gen: RTL

- Transmitter side of the frame-sync interface whose receiver is vsync_ctrlr.
- Generates a registered vsync pulse train with programmable period and pulse width, for a programmable number of frames or free-running.
- Used as the on-chip sync source and as the stimulus driver for vsync_ctrlr benches.
- Sits on the clk domain and is reset by the logic reset from reset_ctrlr.

---
 rtl/vsync_gen.sv | 82 ++++++++
 1 files changed

// File: rtl/vsync_gen.sv
// vsync_gen: registered vsync pulse-train generator with programmable period, width and frame count
module vsync_gen #(
  parameter int   PERIOD_CYCLES = 1000,
  parameter int   PULSE_CYCLES  = 4,
  parameter int   NUM_FRAMES    = 8,
  parameter logic VS_POL        = 1'b1,
  parameter int   CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             vsync,
  output logic             sof,
  output logic             busy,
  output logic             finished,
  output logic [CNT_W-1:0] frame_count
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAMES      = CNT_W'(NUM_FRAMES);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, fc_q, fc_d;
  logic vsync_q, sof_q, busy_q, fin_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = PULSE;
        cnt_d   = '0;
        fc_d    = '0;
      end
      PULSE: if (abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + ONE;
        state_d = (cnt_q == PULSE_LAST) ? GAP : PULSE;
      end
      GAP: if (abort) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == PERIOD_LAST) begin
        cnt_d   = '0;
        fc_d    = fc_q + ONE;
        state_d = (NUM_FRAMES != 0 && fc_d == FRAMES) ? DONE : PULSE;
      end else begin
        cnt_d   = cnt_q + ONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are flops loaded from the next state, so they align with state_q without input paths
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fc_q    <= '0;
      vsync_q <= ~VS_POL;
      sof_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      vsync_q <= (state_d == PULSE) ? VS_POL : ~VS_POL;
      sof_q   <= (state_d == PULSE) && (cnt_d == '0);
      busy_q  <= (state_d == PULSE) || (state_d == GAP);
      fin_q   <= (state_d == DONE);
    end
  end
  assign vsync       = vsync_q;
  assign sof         = sof_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
  assign frame_count = fc_q;
endmodule
